csr_trap_ctrl: RTL and testbench

- Parametrised machine-mode trap controller for the multicycle rv32ima core. Supports M and U privilege only.
- Generalises the existing CSR exception logic:
  - NUM_IRQ interrupt lines, each configurable as level or edge.
  - Fixed-priority interrupt arbitration.
  - Vectored mtvec.
  - Request/acknowledge handshake with the main FSM, so interrupts are taken only at instruction boundaries.
- Owns mstatus, mie, mip, mtvec, mepc, mcause, mtval and privilege_mode. The cycle/instret counters stay outside this block.

---
 rtl/csr_trap_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap controller: CSR file, interrupt synchronisation/arbitration,
// trap entry/return and privilege tracking for the multicycle rv32ima core.
module csr_trap_ctrl #(
  parameter int unsigned NUM_IRQ     = 12,
  parameter logic [31:0] IMPL_MASK   = 32'h0000_0888,
  parameter logic [31:0] EDGE_MASK   = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_INIT  = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  input  logic               csr_we,
  input  logic [31:0]        csr_wdata,
  input  logic               csr_re,
  output logic [31:0]        csr_rdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               instr_boundary,
  input  logic               exception_event,
  input  logic [30:0]        exc_cause,
  input  logic [31:0]        pc,
  input  logic [31:0]        badaddr,
  input  logic               mret,
  output logic               trap_req,
  input  logic               trap_ack,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic [1:0]         privilege_mode,
  output logic               mret_fault,
  output logic               wfi_wake
);

  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMie      = 12'h304;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMtval    = 12'h343;
  localparam logic [11:0] CsrMip      = 12'h344;

  localparam logic [1:0] PrivM = 2'b11;
  localparam logic [1:0] PrivU = 2'b00;

  localparam logic [31:0] LineMask   = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << NUM_IRQ) - 32'd1);
  localparam logic [31:0] ImplLines  = IMPL_MASK & LineMask;
  localparam logic [31:0] EdgeLines  = ImplLines & EDGE_MASK;
  localparam logic [31:0] LevelLines = ImplLines & ~EDGE_MASK;

  typedef enum logic [1:0] {StIdle, StReq, StCommit} state_e;

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [1:0]  priv_q, priv_d;
  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [1:0]  mst_mpp_q, mst_mpp_d;
  logic        mst_mprv_q, mst_mprv_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] edge_pend_q, edge_pend_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        mret_fault_q, mret_fault_d;
  logic [31:0] irq_prev_q;

  logic [NUM_IRQ-1:0] irq_sync;
  logic [31:0] irq_ext, irq_rise, mip, pend, mstatus, trap_base, irq_target;
  logic        irq_en, exc, commit, mret_m, mret_u, csr_wr;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign irq_sync = irq_in;
  end else begin : g_sync
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign irq_sync = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    irq_ext = '0;
    irq_ext[NUM_IRQ-1:0] = irq_sync;
  end

  // Fixed priority 11 > 3 > 7, then highest index among the rest.
  function automatic logic [4:0] pick_irq(input logic [31:0] p);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if (p[i]) c = 5'(i);
    end
    if (p[7])  c = 5'd7;
    if (p[3])  c = 5'd3;
    if (p[11]) c = 5'd11;
    return c;
  endfunction

  assign irq_rise = irq_ext & ~irq_prev_q & EdgeLines;
  assign mip      = (irq_ext & LevelLines) | edge_pend_q;
  assign pend     = mip & mie_q;
  assign irq_en   = (|pend) && (mst_mie_q || (priv_q == PrivU));
  assign wfi_wake = |pend;

  assign mstatus    = {14'b0, mst_mprv_q, 4'b0, mst_mpp_q, 3'b0, mst_mpie_q, 3'b0, mst_mie_q,
                       3'b0};
  assign trap_base  = {mtvec_q[31:2], 2'b00};
  assign irq_target = (mtvec_q[1:0] == 2'b01) ? trap_base + {25'b0, code_q, 2'b00}
                                              : trap_base;

  // Event precedence: exception > commit > mret > CSR write.
  assign exc    = exception_event;
  assign commit = (state_q == StCommit) && !exc;
  assign mret_m = mret && !exc && !commit && (priv_q == PrivM);
  assign mret_u = mret && !exc && !commit && (priv_q == PrivU);
  assign csr_wr = csr_we && (priv_q == PrivM);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (!exc && irq_en && instr_boundary) begin
          state_d = StReq;
          code_d  = pick_irq(pend);
        end
      end
      StReq: begin
        if (exc)                 state_d = StIdle;
        else if (trap_ack)       state_d = StCommit;
        else if (!pend[code_q])  state_d = StIdle;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    priv_d           = priv_q;
    mst_mie_d        = mst_mie_q;
    mst_mpie_d       = mst_mpie_q;
    mst_mpp_d        = mst_mpp_q;
    mst_mprv_d       = mst_mprv_q;
    mie_d            = mie_q;
    edge_pend_d      = edge_pend_q | irq_rise;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    redirect_valid_d = exc || commit || mret_m;
    redirect_pc_d    = redirect_pc_q;
    mret_fault_d     = mret_u;

    if (csr_wr) begin
      case (csr_addr)
        CsrMstatus: begin
          if (!(exc || commit || mret_m)) begin
            mst_mie_d  = csr_wdata[3];
            mst_mpie_d = csr_wdata[7];
            mst_mprv_d = csr_wdata[17];
            // MPP only holds legal modes; reserved encodings keep the old value.
            if (csr_wdata[12:11] == PrivU || csr_wdata[12:11] == PrivM) begin
              mst_mpp_d = csr_wdata[12:11];
            end
          end
        end
        CsrMie:      mie_d       = csr_wdata & ImplLines;
        // An edge arriving in the same cycle as a clear keeps the bit set.
        CsrMip:      edge_pend_d = (edge_pend_q & csr_wdata) | irq_rise;
        CsrMtvec:    mtvec_d     = {csr_wdata[31:2], 1'b0,
                                    (csr_wdata[1:0] == 2'b01) && VECTORED_EN};
        CsrMscratch: mscratch_d  = csr_wdata;
        CsrMepc:     mepc_d      = {csr_wdata[31:2], 2'b00};
        CsrMcause:   mcause_d    = csr_wdata;
        CsrMtval:    mtval_d     = csr_wdata;
        default: ;
      endcase
    end

    if (mret_m) begin
      mst_mie_d     = mst_mpie_q;
      mst_mpie_d    = 1'b1;
      priv_d        = mst_mpp_q;
      mst_mpp_d     = PrivU;
      if (mst_mpp_q != PrivM) mst_mprv_d = 1'b0;
      redirect_pc_d = mepc_q;
    end

    if (exc || commit) begin
      mepc_d     = pc;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      mst_mpp_d  = priv_q;
      priv_d     = PrivM;
    end

    if (commit) begin
      mcause_d      = {1'b1, 26'b0, code_q};
      mtval_d       = '0;
      redirect_pc_d = irq_target;
    end

    if (exc) begin
      mcause_d      = {1'b0, exc_cause};
      mtval_d       = (badaddr == 32'hFFFF_FFFF) ? pc : badaddr;
      redirect_pc_d = trap_base;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      code_q           <= '0;
      priv_q           <= PrivM;
      mst_mie_q        <= 1'b0;
      mst_mpie_q       <= 1'b0;
      mst_mpp_q        <= PrivM;
      mst_mprv_q       <= 1'b0;
      mie_q            <= '0;
      edge_pend_q      <= '0;
      mtvec_q          <= MTVEC_INIT;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mret_fault_q     <= 1'b0;
      irq_prev_q       <= '0;
    end else begin
      state_q          <= state_d;
      code_q           <= code_d;
      priv_q           <= priv_d;
      mst_mie_q        <= mst_mie_d;
      mst_mpie_q       <= mst_mpie_d;
      mst_mpp_q        <= mst_mpp_d;
      mst_mprv_q       <= mst_mprv_d;
      mie_q            <= mie_d;
      edge_pend_q      <= edge_pend_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mret_fault_q     <= mret_fault_d;
      irq_prev_q       <= irq_ext;
    end
  end

  always_comb begin
    csr_rdata = '0;
    if (csr_re) begin
      case (csr_addr)
        CsrMstatus:  csr_rdata = mstatus;
        CsrMie:      csr_rdata = mie_q;
        CsrMip:      csr_rdata = mip;
        CsrMtvec:    csr_rdata = mtvec_q;
        CsrMscratch: csr_rdata = mscratch_q;
        CsrMepc:     csr_rdata = mepc_q;
        CsrMcause:   csr_rdata = mcause_q;
        CsrMtval:    csr_rdata = mtval_q;
        default:     csr_rdata = '0;
      endcase
    end
  end

  assign trap_req       = (state_q == StReq);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign privilege_mode = priv_q;
  assign mret_fault     = mret_fault_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: CSR reads checked directly, redirects
// checked through an expected-target queue filled when each trigger is driven.
module tb_csr_trap_ctrl;

  localparam int unsigned NIrq = 17;
  localparam logic [11:0] AMstatus  = 12'h300;
  localparam logic [11:0] AMie      = 12'h304;
  localparam logic [11:0] AMtvec    = 12'h305;
  localparam logic [11:0] AMscratch = 12'h340;
  localparam logic [11:0] AMepc     = 12'h341;
  localparam logic [11:0] AMcause   = 12'h342;
  localparam logic [11:0] AMtval    = 12'h343;
  localparam logic [11:0] AMip      = 12'h344;

  logic            clk = 1'b0;
  logic            reset;
  logic [11:0]     csr_addr;
  logic            csr_we, csr_re;
  logic [31:0]     csr_wdata, csr_rdata;
  logic [NIrq-1:0] irq_in;
  logic            instr_boundary, exception_event, mret, trap_ack;
  logic [30:0]     exc_cause;
  logic [31:0]     pc, badaddr, redirect_pc;
  logic            trap_req, redirect_valid, mret_fault, wfi_wake;
  logic [1:0]      privilege_mode;

  int n_checks = 0;
  int n_pass   = 0;
  int n_redir  = 0;
  logic [31:0] exp_q[$];

  csr_trap_ctrl #(
    .NUM_IRQ    (NIrq),
    .IMPL_MASK  (32'h0001_0888),
    .EDGE_MASK  (32'h0001_0000),
    .SYNC_STAGES(2),
    .MTVEC_INIT (32'h0000_0100),
    .VECTORED_EN(1'b1)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .csr_re         (csr_re),
    .csr_rdata      (csr_rdata),
    .irq_in         (irq_in),
    .instr_boundary (instr_boundary),
    .exception_event(exception_event),
    .exc_cause      (exc_cause),
    .pc             (pc),
    .badaddr        (badaddr),
    .mret           (mret),
    .trap_req       (trap_req),
    .trap_ack       (trap_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .privilege_mode (privilege_mode),
    .mret_fault     (mret_fault),
    .wfi_wake       (wfi_wake)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    tick(1);
    csr_we    = 1'b0;
  endtask

  task automatic csr_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    csr_re   = 1'b1;
    #1;
    chk(tag, csr_rdata, exp);
    csr_re   = 1'b0;
    #1;
  endtask

  task automatic wait_trap(input string tag, output int cycles);
    cycles = 0;
    while (!trap_req && cycles < 12) begin
      tick(1);
      cycles++;
    end
    chk(tag, {31'b0, trap_req}, 32'd1);
  endtask

  task automatic ack_trap(input logic [31:0] exp_target);
    exp_q.push_back(exp_target);
    trap_ack = 1'b1;
    tick(1);
    trap_ack = 1'b0;
  endtask

  task automatic do_mret(input logic [31:0] exp_target, input bit expect_redirect);
    if (expect_redirect) exp_q.push_back(exp_target);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
  endtask

  // Redirect monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && redirect_valid) begin
      n_redir++;
      if (exp_q.size() == 0) chk("redir_unexpected", redirect_pc, 32'hFFFF_FFFF);
      else chk("redir_pc", redirect_pc, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset = 1'b1;
    csr_addr = '0; csr_we = 1'b0; csr_wdata = '0; csr_re = 1'b0;
    irq_in = '0; instr_boundary = 1'b1; exception_event = 1'b0; exc_cause = '0;
    pc = 32'h0000_2000; badaddr = '0; mret = 1'b0; trap_ack = 1'b0;
    tick(3);
    reset = 1'b0;

    csr_check("rst_mtvec", AMtvec, 32'h0000_0100);
    csr_check("rst_mstatus", AMstatus, 32'h0000_1800);
    chk("rst_priv", {30'b0, privilege_mode}, 32'd3);
    chk("rst_trap_req", {31'b0, trap_req}, 32'd0);
    chk("rst_mcause", csr_rdata, 32'd0);

    // Simultaneous lines 7 and 11: 11 wins, direct mode target = base.
    tick(1);
    csr_write(AMie, 32'hFFFF_FFFF);
    csr_check("mie_masked", AMie, 32'h0001_0888);
    csr_write(AMstatus, 32'h0000_1808);
    irq_in[7] = 1'b1; irq_in[11] = 1'b1;
    wait_trap("trap1_req", cyc);
    chk("trap1_latency", cyc, 32'd3);
    ack_trap(32'h0000_0100);
    chk("trap1_req_drop", {31'b0, trap_req}, 32'd0);
    irq_in = '0;
    tick(1);
    csr_check("trap1_mcause", AMcause, 32'h8000_000B);
    csr_check("trap1_mstatus", AMstatus, 32'h0000_1880);
    csr_check("trap1_mepc", AMepc, 32'h0000_2000);
    tick(4);

    // Vectored mtvec with line 3, then mret back.
    csr_write(AMtvec, 32'h0000_1001);
    csr_check("mtvec_vec", AMtvec, 32'h0000_1001);
    csr_write(AMstatus, 32'h0000_1808);
    pc = 32'h0000_3000;
    irq_in[3] = 1'b1;
    wait_trap("trap2_req", cyc);
    ack_trap(32'h0000_100C);
    irq_in = '0;
    tick(5);
    csr_check("trap2_mcause", AMcause, 32'h8000_0003);
    csr_check("trap2_mepc", AMepc, 32'h0000_3000);
    do_mret(32'h0000_3000, 1'b1);
    csr_check("mret_mstatus", AMstatus, 32'h0000_0088);
    chk("mret_priv", {30'b0, privilege_mode}, 32'd3);

    // Exception while an interrupt is held in REQ.
    pc = 32'h0000_4000;
    irq_in[11] = 1'b1;
    wait_trap("trap3_req", cyc);
    exp_q.push_back(32'h0000_1000);
    exception_event = 1'b1; exc_cause = 31'd2; badaddr = 32'hFFFF_FFFF;
    tick(1);
    exception_event = 1'b0;
    chk("exc_trap_req", {31'b0, trap_req}, 32'd0);
    irq_in = '0;
    tick(1);
    csr_check("exc_mcause", AMcause, 32'h0000_0002);
    csr_check("exc_mtval", AMtval, 32'h0000_4000);
    csr_check("exc_mepc", AMepc, 32'h0000_4000);
    csr_check("exc_mstatus", AMstatus, 32'h0000_1880);
    tick(4);

    // Edge-triggered line 16: sticky pending, edge beats a same-cycle clear.
    csr_write(AMie, 32'h0001_0888);
    irq_in[16] = 1'b1;
    tick(1);
    irq_in[16] = 1'b0;
    tick(4);
    csr_check("edge_sticky", AMip, 32'h0001_0000);
    chk("wfi_wake_set", {31'b0, wfi_wake}, 32'd1);
    csr_write(AMip, 32'h0000_0000);
    csr_check("edge_clear", AMip, 32'h0000_0000);
    chk("wfi_wake_clr", {31'b0, wfi_wake}, 32'd0);
    irq_in[16] = 1'b1;
    tick(1);
    irq_in[16] = 1'b0;
    tick(1);
    csr_write(AMip, 32'h0000_0000);
    csr_check("edge_vs_clear", AMip, 32'h0001_0000);
    csr_write(AMip, 32'h0000_0000);

    // Drop to U mode, then an illegal mret and a blocked CSR write.
    csr_write(AMie, 32'h0000_0000);
    csr_write(AMscratch, 32'h1234_5678);
    csr_check("mscratch_m", AMscratch, 32'h1234_5678);
    csr_write(AMstatus, 32'h0000_0000);
    csr_check("mstatus_mpp_u", AMstatus, 32'h0000_0000);
    do_mret(32'h0000_4000, 1'b1);
    chk("u_priv", {30'b0, privilege_mode}, 32'd0);
    csr_check("u_mstatus", AMstatus, 32'h0000_0080);
    do_mret(32'h0, 1'b0);
    chk("mret_fault_pulse", {31'b0, mret_fault}, 32'd1);
    tick(1);
    chk("mret_fault_once", {31'b0, mret_fault}, 32'd0);
    chk("u_priv_kept", {30'b0, privilege_mode}, 32'd0);
    csr_write(AMscratch, 32'hDEAD_BEEF);
    csr_check("mscratch_u_blocked", AMscratch, 32'h1234_5678);

    tick(3);
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("redir_count", n_redir, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
